cpu_sram_responder: RTL
=======================

Name: cpu_sram_responder

Overview:
Memory-side responder for the CPU core's instruction and data SRAM ports, used as the memory the core fetches from and loads from / stores to. It holds a word array shared by both ports. Each port gets a fixed-latency read path; writes go through the data port only. It also checks address range and alignment and keeps an error counter for the bench.

Parameters:
ADDR_BASE, 32'h1c00_0000, byte address of word 0
AW, 14, word-address width; array depth is 2**AW words
READ_LAT, 1, read latency in cycles, legal range 1..4

Ports:
clk  input  1  single clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clk
inst_sram_we  input  1  instruction-port write strobe (illegal; counted as error)
inst_sram_addr  input  32  instruction-port byte address
inst_sram_wdata  input  32  instruction-port write data (ignored)
inst_sram_rdata  output  32  instruction-port read data
data_sram_we  input  1  data-port write strobe
data_sram_addr  input  32  data-port byte address
data_sram_wdata  input  32  data-port write data
data_sram_rdata  output  32  data-port read data
err_count  output  16  saturating count of access errors
err_flag  output  1  sticky flag, set by first error

Behaviour:
- Reset (resetn=0 at a clock edge) clears the following to 0:
  - inst_sram_rdata, data_sram_rdata and every internal read-pipeline stage
  - err_count and err_flag
- Reset does not clear the memory array. Contents survive reset.
- Address decode, per port, every cycle:
  - off = addr - ADDR_BASE, 32-bit modulo.
  - in_range = off < 4*2**AW, unsigned compare.
  - aligned = addr[1:0] == 0.
  - word index = off[AW+1:2].
- Reads (no handshake; both ports read every cycle):
  - Address sampled at edge N; rdata valid after edge N+READ_LAT-1 and held until the next edge.
  - READ_LAT=1: registered output, so the read addressed at edge N is visible during cycle N+1.
  - Each extra stage adds one cycle.
  - An out-of-range or misaligned address returns 32'h0000_0000 through the same pipeline.
- Writes:
  - Data port writes mem[word index] = data_sram_wdata at the edge only when data_sram_we=1, in range and aligned.
  - Full-word writes only; no byte enables.
  - An illegal write is dropped and the array is unchanged.
  - inst_sram_we=1 never writes and is counted as an error.
- Collisions at the same edge:
  - A data-port write plus a read of the same word on either port returns the OLD contents (read-before-write).
  - The new value is visible to reads sampled at the next edge onward.
- Error events, evaluated at each edge while resetn=1:
  - E_inst = inst_sram_we | (~aligned_i) | (~in_range_i)
  - E_data = (~aligned_d) | (~in_range_d); checked every cycle because the core drives the data address continuously.
  - A verification-mode gate is not provided.
- Error accounting:
  - err_count += E_inst + E_data, range 0..2 per edge, saturating at 16'hFFFF with no wrap.
  - err_flag <= 1 when either event fires, and stays set until reset.
- Reset mid-operation:
  - In-flight reads are discarded; outputs read 0 for READ_LAT cycles after reset release, then resume normally.
  - A write coinciding with the reset edge is still performed if legal, because reset does not gate array writes.
- Both ports are independent. There is no arbitration and no stall, and the array is true dual-read, single-write.

Test Plan:
- READ_LAT=1:
  - Data write at 32'h1c00_0010 with 32'hDEAD_BEEF, then inst read of 32'h1c00_0010 at the next edge.
  - Required: inst_sram_rdata=32'hDEAD_BEEF one cycle after the address edge; err_count=0.
- READ_LAT=3, reading back-to-back addresses 32'h1c00_0000, _0004, _0008 holding 1, 2, 3 on the data port.
  - Required: data_sram_rdata shows 1, 2, 3 on consecutive cycles starting 3 cycles after the first address.
- Same edge: data write 32'h5555_5555 to 32'h1c00_0020 (old value 32'h1111_1111) with an inst read of the same address.
  - Required: inst read returns 32'h1111_1111.
  - Required: a repeat read on the next edge returns 32'h5555_5555.
- Illegal accesses:
  - Inst address 32'h1bff_fffc: rdata=0 and err_count +1.
  - Data write to 32'h1c00_0002: rdata=0, no array change, err_flag=1.
  - inst_sram_we=1 at a valid address: error counted, no write.
- Saturation: both ports erroneous every cycle for 40000 cycles.
  - Required: err_count stops at 16'hFFFF.
- Reset mid-read at READ_LAT=2: assert resetn=0 for one edge while reads are in flight.
  - Required: both rdata=0 and err_count=0 the cycle after the reset edge.
  - Required: previously written memory words still read back correctly afterwards.

Source files
------------

// File: rtl/cpu_sram_responder.sv
// cpu_sram_responder: word-array memory serving the CPU instruction and data SRAM ports.
//   clk, resetn                   : clock and synchronous active-low reset
//   inst_sram_we/addr/wdata/rdata : instruction port (read-only; a write strobe is an error)
//   data_sram_we/addr/wdata/rdata : data port (read every cycle, full-word writes)
//   err_count, err_flag           : saturating error count and sticky error flag
module cpu_sram_responder #(
    parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
    parameter int          AW        = 14,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] err_count,
    output logic        err_flag
);
    localparam logic [32:0] SPAN = 33'd4 << AW;
    logic [31:0] mem [2**AW];
    logic [31:0] off_i, off_d;
    logic        ok_i, ok_d, e_i, e_d;
    logic [31:0] ipipe_d [READ_LAT];
    logic [31:0] ipipe_q [READ_LAT];
    logic [31:0] dpipe_d [READ_LAT];
    logic [31:0] dpipe_q [READ_LAT];
    logic [16:0] cnt_sum;
    logic [15:0] err_count_d, err_count_q;
    logic        err_flag_d, err_flag_q;
    logic        unused_wdata;
    assign unused_wdata = ^inst_sram_wdata;
    always_comb begin
        off_i = inst_sram_addr - ADDR_BASE;
        off_d = data_sram_addr - ADDR_BASE;
        ok_i = ({1'b0, off_i} < SPAN) && (inst_sram_addr[1:0] == 2'b00);
        ok_d = ({1'b0, off_d} < SPAN) && (data_sram_addr[1:0] == 2'b00);
        e_i = inst_sram_we | ~ok_i;
        e_d = ~ok_d;
        // Array read happens before this edge's write lands, giving read-before-write on collisions.
        ipipe_d[0] = ok_i ? mem[off_i[AW+1:2]] : 32'h0;
        dpipe_d[0] = ok_d ? mem[off_d[AW+1:2]] : 32'h0;
        for (int k = 1; k < READ_LAT; k++) begin
            ipipe_d[k] = ipipe_q[k-1];
            dpipe_d[k] = dpipe_q[k-1];
        end
        cnt_sum = {1'b0, err_count_q} + 17'(e_i) + 17'(e_d);
        err_count_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        err_flag_d = err_flag_q | e_i | e_d;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < READ_LAT; k++) begin
                ipipe_q[k] <= 32'h0;
                dpipe_q[k] <= 32'h0;
            end
            err_count_q <= 16'h0;
            err_flag_q  <= 1'b0;
        end else begin
            ipipe_q     <= ipipe_d;
            dpipe_q     <= dpipe_d;
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
        end
    end
    // Array writes are deliberately not gated by reset so contents and in-reset writes persist.
    always_ff @(posedge clk) begin
        if (data_sram_we && ok_d) mem[off_d[AW+1:2]] <= data_sram_wdata;
    end
    assign inst_sram_rdata = ipipe_q[READ_LAT-1];
    assign data_sram_rdata = dpipe_q[READ_LAT-1];
    assign err_count       = err_count_q;
    assign err_flag        = err_flag_q;
endmodule
